// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module   : pll_lock_supervisor
// Brief    : Synchronises the PLL lock flag, qualifies it for a stable period,
//            and generates the core system reset. Tracks loss-of-lock events.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_lock_supervisor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clock_in,
    input  logic             resetn,
    input  logic             locked,
    input  logic             clear_lost,
    output logic             sys_resetn,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int c_max_cycles = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_st_wait_lock = 2'd0;
    localparam logic [1:0] c_st_stabilize = 2'd1;
    localparam logic [1:0] c_st_run       = 2'd2;
    localparam logic [1:0] c_st_holdoff   = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic                   sys_resetn_q, sys_resetn_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]       loss_count_q, loss_count_d;
    logic                   w_lock_s;
    logic                   w_loss;

    assign w_lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], locked};
        state_d      = state_q;
        cnt_d        = cnt_q;
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        w_loss       = 1'b0;

        case (state_q)
            c_st_wait_lock: begin
                cnt_d = '0;
                if (w_lock_s) begin
                    state_d = c_st_stabilize;
                end
            end
            c_st_stabilize: begin
                // Any low sample restarts qualification from scratch
                if (!w_lock_s) begin
                    state_d = c_st_wait_lock;
                    cnt_d   = '0;
                end else if (cnt_q == c_lock_last) begin
                    state_d = c_st_run;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_run: begin
                cnt_d = '0;
                if (!w_lock_s) begin
                    state_d = c_st_holdoff;
                    w_loss  = 1'b1;
                end
            end
            c_st_holdoff: begin
                if (cnt_q == c_hold_last) begin
                    state_d = c_st_wait_lock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = c_st_wait_lock;
                cnt_d   = '0;
            end
        endcase

        // A new loss takes priority over a coincident clear request
        if (w_loss) begin
            lock_lost_d = 1'b1;
        end else if (clear_lost) begin
            lock_lost_d = 1'b0;
        end

        if (w_loss && (loss_count_q != {CNT_W{1'b1}})) begin
            loss_count_d = loss_count_q + 1'b1;
        end

        sys_resetn_d = (state_d == c_st_run);
        ready_d      = (state_d == c_st_run);
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            sync_q       <= '0;
            state_q      <= c_st_wait_lock;
            cnt_q        <= '0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_resetn_q <= sys_resetn_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign sys_resetn = sys_resetn_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Brief    : Scoreboard bench; expected output-change events are queued by the
//            stimulus and matched by a monitor on every observed change.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_CYCLES = 8;
    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 2;

    logic             clock_in;
    logic             resetn;
    logic             locked;
    logic             clear_lost;
    logic             sys_resetn;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;
    logic [1:0]       state;

    typedef struct {
        int               cyc;
        logic [1:0]       st;
        logic             sr;
        logic             rdy;
        logic             lost;
        logic [CNT_W-1:0] lc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  n;

    pll_lock_supervisor #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clock_in   (clock_in),
        .resetn     (resetn),
        .locked     (locked),
        .clear_lost (clear_lost),
        .sys_resetn (sys_resetn),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count),
        .state      (state)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Monitor: every change in the observed output tuple must match the next queued event
    logic [CNT_W+4:0] cur, prev;
    logic             have_prev = 1'b0;
    ev_t              e;

    always @(negedge clock_in) begin
        cur = {state, sys_resetn, ready, lock_lost, loss_count};
        if (!have_prev || (cur !== prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d got st=%0d sr=%0b rdy=%0b lost=%0b cnt=%0d, required no change",
                         cyc, state, sys_resetn, ready, lock_lost, loss_count);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (cur !== {e.st, e.sr, e.rdy, e.lost, e.lc})) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d st=%0d sr=%0b rdy=%0b lost=%0b cnt=%0d, required cyc=%0d st=%0d sr=%0b rdy=%0b lost=%0b cnt=%0d",
                             cyc, state, sys_resetn, ready, lock_lost, loss_count,
                             e.cyc, e.st, e.sr, e.rdy, e.lost, e.lc);
                end
            end
        end
        prev      = cur;
        have_prev = 1'b1;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock_in);
        #2;
    endtask

    task automatic expect_ev(input int c, input logic [1:0] st, input logic sr,
                             input logic lost, input logic [CNT_W-1:0] lc);
        ev_t ev;
        ev.cyc  = c;
        ev.st   = st;
        ev.sr   = sr;
        ev.rdy  = sr;
        ev.lost = lost;
        ev.lc   = lc;
        exp_q.push_back(ev);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({state, sys_resetn, ready, lock_lost, loss_count} !== '0) begin
            errors++;
            $display("FAIL %s: got st=%0d sr=%0b rdy=%0b lost=%0b cnt=%0d, required all zero",
                     name, state, sys_resetn, ready, lock_lost, loss_count);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        locked     = 1'b0;
        clear_lost = 1'b0;
        expect_ev(1, 2'd0, 1'b0, 1'b0, 2'd0);
        tick(3);
        resetn = 1'b1;
        tick(2);

        // Clean lock
        n = cyc; locked = 1'b1;
        expect_ev(n + 3,  2'd1, 1'b0, 1'b0, 2'd0);
        expect_ev(n + 11, 2'd2, 1'b1, 1'b0, 2'd0);
        tick(14);

        // One-cycle drop in RUN; HOLDOFF ignores the restored lock
        n = cyc; locked = 1'b0;
        expect_ev(n + 3,  2'd3, 1'b0, 1'b1, 2'd1);
        expect_ev(n + 7,  2'd0, 1'b0, 1'b1, 2'd1);
        expect_ev(n + 8,  2'd1, 1'b0, 1'b1, 2'd1);
        expect_ev(n + 16, 2'd2, 1'b1, 1'b1, 2'd1);
        tick(1); locked = 1'b1; tick(17);

        // Long drop back to WAIT_LOCK, then a glitch during stabilisation
        n = cyc; locked = 1'b0;
        expect_ev(n + 3, 2'd3, 1'b0, 1'b1, 2'd2);
        expect_ev(n + 7, 2'd0, 1'b0, 1'b1, 2'd2);
        tick(10);
        n = cyc; locked = 1'b1;
        expect_ev(n + 3,  2'd1, 1'b0, 1'b1, 2'd2);
        expect_ev(n + 8,  2'd0, 1'b0, 1'b1, 2'd2);
        expect_ev(n + 9,  2'd1, 1'b0, 1'b1, 2'd2);
        expect_ev(n + 17, 2'd2, 1'b1, 1'b1, 2'd2);
        tick(5); locked = 1'b0; tick(1); locked = 1'b1; tick(14);

        // Losses 3..5: the counter reaches 3 and holds there
        for (int k = 3; k <= 5; k++) begin
            n = cyc; locked = 1'b0;
            expect_ev(n + 3,  2'd3, 1'b0, 1'b1, 2'd3);
            expect_ev(n + 7,  2'd0, 1'b0, 1'b1, 2'd3);
            expect_ev(n + 8,  2'd1, 1'b0, 1'b1, 2'd3);
            expect_ev(n + 16, 2'd2, 1'b1, 1'b1, 2'd3);
            tick(1); locked = 1'b1; tick(17);
        end

        // Clear pulse in RUN
        n = cyc; clear_lost = 1'b1;
        expect_ev(n + 1, 2'd2, 1'b1, 1'b0, 2'd3);
        tick(1); clear_lost = 1'b0; tick(3);

        // Clear coincident with a new loss: the set wins
        n = cyc; locked = 1'b0;
        expect_ev(n + 3,  2'd3, 1'b0, 1'b1, 2'd3);
        expect_ev(n + 7,  2'd0, 1'b0, 1'b1, 2'd3);
        expect_ev(n + 8,  2'd1, 1'b0, 1'b1, 2'd3);
        expect_ev(n + 16, 2'd2, 1'b1, 1'b1, 2'd3);
        tick(1); locked = 1'b1;
        tick(1); clear_lost = 1'b1;
        tick(1); clear_lost = 1'b0;
        tick(15);

        // Async reset in RUN, with locked already high at release
        n = cyc;
        expect_ev(n, 2'd0, 1'b0, 1'b0, 2'd0);
        resetn = 1'b0;
        #1;
        check_zero("async_reset_run");
        tick(2);
        n = cyc; resetn = 1'b1;
        expect_ev(n + 3, 2'd1, 1'b0, 1'b0, 2'd0);
        tick(5);

        // Async reset in STABILIZE, then a full restart
        n = cyc;
        expect_ev(n, 2'd0, 1'b0, 1'b0, 2'd0);
        resetn = 1'b0;
        #1;
        check_zero("async_reset_stabilize");
        tick(1);
        n = cyc; resetn = 1'b1;
        expect_ev(n + 3,  2'd1, 1'b0, 1'b0, 2'd0);
        expect_ev(n + 11, 2'd2, 1'b1, 1'b0, 2'd0);
        tick(14);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d events never observed, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
